dma_wr_burst_master: RTL and testbench

- Write-side Avalon-MM burst master downstream of the sg_dma write block.
- Takes one write command (start address plus byte count) and a 256-bit data stream from the DMA data path.
- Splits the command into Avalon-MM write bursts of at most MAX_BURST beats and drives them onto the memory fabric.
- Signals completion back to the DMA so the status update can proceed.

---
 rtl/dma_pkg.sv | 29 ++
 rtl/dma_wr_burst_master.sv | 118 +++++++++++
 tb/tb_dma_wr_burst_master.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA write-side burst master.
// Beat size is fixed at 32 bytes, so byte counts convert to beats with a shift.
package dma_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StWrite,
        StDone
    } state_e;

    localparam int unsigned BEAT_BYTES = 32;
    localparam int unsigned BEAT_SHIFT = 5;

    function automatic int unsigned beats_from_bytes(input int unsigned nbytes);
        return (nbytes + BEAT_BYTES - 1) >> BEAT_SHIFT;
    endfunction

    // A tail of 0 means the last beat is full.
    function automatic logic [BEAT_BYTES-1:0] tail_be_mask(input logic [BEAT_SHIFT-1:0] tail);
        logic [BEAT_BYTES-1:0] one;
        one = BEAT_BYTES'(1);
        if (tail == '0) begin
            return '1;
        end
        return (one << tail) - one;
    endfunction

endpackage

// File: rtl/dma_wr_burst_master.sv
// Write-side Avalon-MM burst master: splits one DMA write command into bursts of at most
// MAX_BURST beats and passes the data stream straight through to the fabric.
module dma_wr_burst_master
    import dma_pkg::*;
#(
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned BCOUNT_W  = 11,
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned BURST_W   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [ADDR_W-1:0]   cmd_addr_i,
    input  logic [BCOUNT_W-1:0] cmd_bcount_i,
    input  logic                data_valid_i,
    input  logic [DATA_W-1:0]   data_i,
    output logic                data_ready_o,
    output logic                avm_write_o,
    output logic [ADDR_W-1:0]   avm_address_o,
    output logic [BURST_W-1:0]  avm_burstcount_o,
    output logic [DATA_W-1:0]   avm_writedata_o,
    output logic [DATA_W/8-1:0] avm_byteenable_o,
    input  logic                avm_waitrequest_i,
    output logic                done_o,
    output logic                busy_o
);

    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned BEAT_W = BCOUNT_W - 4;

    state_e                  state_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [ADDR_W-1:0]       avm_address_q;
    logic [BEAT_W-1:0]       remaining_q;
    logic [BURST_W-1:0]      burst_len_q;
    logic [BURST_W-1:0]      beat_cnt_q;
    logic [BEAT_SHIFT-1:0]   tail_q;

    logic                    in_write;
    logic                    xfer;
    logic                    last_cmd_beat;
    logic [BEAT_W-1:0]       next_len;

    assign in_write      = (state_q == StWrite);
    assign xfer          = in_write && data_valid_i && !avm_waitrequest_i;
    assign last_cmd_beat = (remaining_q == BEAT_W'(1));
    assign next_len      = (remaining_q > BEAT_W'(MAX_BURST)) ? BEAT_W'(MAX_BURST) : remaining_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            avm_address_q <= '0;
            remaining_q   <= '0;
            burst_len_q   <= '0;
            beat_cnt_q    <= '0;
            tail_q        <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid_i) begin
                        addr_q      <= cmd_addr_i & ~ADDR_W'(BEAT_BYTES - 1);
                        remaining_q <= BEAT_W'(beats_from_bytes(32'(cmd_bcount_i)));
                        tail_q      <= cmd_bcount_i[BEAT_SHIFT-1:0];
                        state_q     <= StSetup;
                    end
                end
                StSetup: begin
                    // A zero-byte command passes through here so done lands two cycles after accept.
                    if (remaining_q == '0) begin
                        state_q <= StDone;
                    end else begin
                        avm_address_q <= addr_q;
                        burst_len_q   <= BURST_W'(next_len);
                        beat_cnt_q    <= BURST_W'(next_len);
                        addr_q        <= addr_q + (ADDR_W'(next_len) << BEAT_SHIFT);
                        state_q       <= StWrite;
                    end
                end
                StWrite: begin
                    if (xfer) begin
                        remaining_q <= remaining_q - BEAT_W'(1);
                        beat_cnt_q  <= beat_cnt_q - BURST_W'(1);
                        if (beat_cnt_q == BURST_W'(1)) begin
                            state_q <= last_cmd_beat ? StDone : StSetup;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign cmd_ready_o      = (state_q == StIdle);
    assign busy_o           = (state_q != StIdle);
    assign done_o           = (state_q == StDone);
    assign data_ready_o     = in_write && !avm_waitrequest_i;
    assign avm_write_o      = in_write && data_valid_i;
    assign avm_address_o    = avm_address_q;
    assign avm_burstcount_o = burst_len_q;
    assign avm_writedata_o  = in_write ? data_i : '0;

    always_comb begin
        avm_byteenable_o = '0;
        if (in_write) begin
            avm_byteenable_o = last_cmd_beat ? BE_W'(tail_be_mask(tail_q)) : '1;
        end
    end

endmodule

// File: tb/tb_dma_wr_burst_master.sv
// Randomised scoreboard bench for dma_wr_burst_master: a command-level model predicts every
// fabric beat and done pulse; a monitor pops and compares as the DUT presents them.
module tb_dma_wr_burst_master;

    localparam int unsigned DATA_W    = 256;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned BCOUNT_W  = 11;
    localparam int unsigned MAX_BURST = 8;
    localparam int unsigned BURST_W   = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                cmd_valid_i;
    logic                cmd_ready_o;
    logic [ADDR_W-1:0]   cmd_addr_i;
    logic [BCOUNT_W-1:0] cmd_bcount_i;
    logic                data_valid_i;
    logic [DATA_W-1:0]   data_i;
    logic                data_ready_o;
    logic                avm_write_o;
    logic [ADDR_W-1:0]   avm_address_o;
    logic [BURST_W-1:0]  avm_burstcount_o;
    logic [DATA_W-1:0]   avm_writedata_o;
    logic [DATA_W/8-1:0] avm_byteenable_o;
    logic                avm_waitrequest_i;
    logic                done_o;
    logic                busy_o;

    dma_wr_burst_master #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BCOUNT_W  (BCOUNT_W),
        .MAX_BURST (MAX_BURST),
        .BURST_W   (BURST_W)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .cmd_valid_i       (cmd_valid_i),
        .cmd_ready_o       (cmd_ready_o),
        .cmd_addr_i        (cmd_addr_i),
        .cmd_bcount_i      (cmd_bcount_i),
        .data_valid_i      (data_valid_i),
        .data_i            (data_i),
        .data_ready_o      (data_ready_o),
        .avm_write_o       (avm_write_o),
        .avm_address_o     (avm_address_o),
        .avm_burstcount_o  (avm_burstcount_o),
        .avm_writedata_o   (avm_writedata_o),
        .avm_byteenable_o  (avm_byteenable_o),
        .avm_waitrequest_i (avm_waitrequest_i),
        .done_o            (done_o),
        .busy_o            (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_done;
        logic [31:0] addr;
        logic [3:0]  bc;
        logic [255:0] data;
        logic [31:0] be;
    } exp_t;

    exp_t         exp_q[$];
    logic [255:0] data_q[$];
    int           checks = 0;
    int           errors = 0;
    int           beats_seen = 0;
    int           val_mode = 0;   // 0: always valid, 1: random, 2: alternate cycles
    int           wr_rand = 0;
    logic         wr_force = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Command-level prediction: beats grouped into bursts of up to MAX_BURST, each beat
    // carrying its burst start address; a done token follows the last beat.
    task automatic model_cmd(input logic [31:0] addr, input int bcount);
        logic [31:0] a;
        int          left;
        int          tail;
        int          len;
        exp_t        e;
        logic [255:0] d;
        a    = addr & 32'hFFFF_FFE0;
        left = (bcount + 31) / 32;
        tail = bcount % 32;
        while (left > 0) begin
            len = (left < int'(MAX_BURST)) ? left : int'(MAX_BURST);
            for (int i = 0; i < len; i++) begin
                for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
                e.is_done = 1'b0;
                e.addr    = a;
                e.bc      = 4'(len);
                e.data    = d;
                e.be      = (left - i == 1 && tail != 0) ? (32'hFFFF_FFFF >> (32 - tail))
                                                          : 32'hFFFF_FFFF;
                exp_q.push_back(e);
                data_q.push_back(d);
            end
            a    = a + 32'(len * 32);
            left = left - len;
        end
        e         = '{default: '0};
        e.is_done = 1'b1;
        exp_q.push_back(e);
    endtask

    // Data source: presents queued beats, pops one on each handshake.
    initial begin
        bit take;
        bit phase;
        bit ok;
        phase        = 1'b0;
        data_valid_i = 1'b0;
        data_i       = '0;
        forever begin
            @(negedge clk);
            take = !reset && data_valid_i && data_ready_o;
            @(posedge clk);
            #1;
            if (take && data_q.size() > 0) void'(data_q.pop_front());
            phase = ~phase;
            ok = data_q.size() > 0 &&
                 (val_mode == 0 || (val_mode == 1 && $urandom_range(0, 99) < 70) ||
                  (val_mode == 2 && phase));
            data_valid_i = ok;
            data_i       = ok ? data_q[0] : '0;
        end
    end

    initial begin
        avm_waitrequest_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            avm_waitrequest_i = (wr_rand != 0) ? ($urandom_range(0, 99) < 30) : wr_force;
        end
    end

    // Monitor: compares every presented write (stalled or not) against the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (avm_write_o) begin
                    if (exp_q.size() == 0 || exp_q[0].is_done) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got addr %0h want no write",
                                 avm_address_o);
                    end else begin
                        check("wr_addr", 256'(avm_address_o), 256'(exp_q[0].addr));
                        check("wr_burstcount", 256'(avm_burstcount_o), 256'(exp_q[0].bc));
                        check("wr_data", avm_writedata_o, exp_q[0].data);
                        check("wr_byteenable", 256'(avm_byteenable_o), 256'(exp_q[0].be));
                        if (!avm_waitrequest_i) begin
                            void'(exp_q.pop_front());
                            beats_seen++;
                        end
                    end
                end
                if (done_o) begin
                    check("done_order", 256'(exp_q.size() > 0 && exp_q[0].is_done), 256'(1));
                    if (exp_q.size() > 0 && exp_q[0].is_done) void'(exp_q.pop_front());
                end
                if (!busy_o) begin
                    check("idle_quiet", {254'(0), data_ready_o, avm_write_o}, 256'(0));
                end
            end
        end
    end

    task automatic send_cmd(input logic [31:0] addr, input int bcount, output bit ok);
        model_cmd(addr, bcount);
        @(posedge clk);
        #1;
        cmd_valid_i  = 1'b1;
        cmd_addr_i   = addr;
        cmd_bcount_i = BCOUNT_W'(bcount);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready_o) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept: got no accept in 200 cycles want accept");
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || busy_o) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_complete"}, 256'(exp_q.size() == 0 && !busy_o), 256'(1));
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int base;
        int stall_cnt;
        int wcyc;
        int n;
        logic [31:0] ra;
        int rb;

        reset        = 1'b1;
        cmd_valid_i  = 1'b0;
        cmd_addr_i   = '0;
        cmd_bcount_i = '0;
        @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 256'(cmd_ready_o), 256'(1));
        check("rst_outputs", {249'(0), busy_o, done_o, avm_write_o, data_ready_o,
              3'b0}, 256'(0));
        check("rst_addr_bc", {220'(0), avm_address_o, avm_burstcount_o}, 256'(0));
        check("rst_byteenable", 256'(avm_byteenable_o), 256'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Two bursts with a partial last beat, plus accept-to-write latency.
        send_cmd(32'h0000_1000, 300, ok);
        @(negedge clk);
        check("lat_setup_no_write", 256'(avm_write_o), 256'(0));
        @(negedge clk);
        check("lat_first_write", 256'(avm_write_o), 256'(1));
        wait_idle("t300");

        // Zero-byte command: no writes, done two cycles after accept.
        send_cmd(32'h0000_0400, 0, ok);
        @(negedge clk);
        check("zero_c1", {254'(0), busy_o, done_o}, 256'(2));
        @(negedge clk);
        check("zero_c2", {254'(0), busy_o, done_o}, 256'(3));
        @(negedge clk);
        check("zero_c3", {254'(0), busy_o, done_o}, 256'(0));
        wait_idle("t0");

        // Waitrequest held for three cycles on the first beat.
        wr_force = 1'b1;
        base = beats_seen;
        stall_cnt = 0;
        send_cmd(32'h0000_2000, 64, ok);
        @(negedge clk);
        repeat (3) begin
            @(negedge clk);
            if (avm_write_o && avm_waitrequest_i) stall_cnt++;
        end
        wr_force = 1'b0;
        wait_idle("tstall");
        check("stall_cycles", 256'(stall_cnt), 256'(3));
        check("stall_transfers", 256'(beats_seen - base), 256'(2));

        // Valid toggling: write follows valid, one burst of eight.
        val_mode = 2;
        base = beats_seen;
        wcyc = 0;
        n = 0;
        send_cmd(32'h0000_3000, 256, ok);
        do begin
            @(negedge clk);
            if (avm_write_o) wcyc++;
            n++;
        end while (busy_o && n < 500);
        wait_idle("ttoggle");
        check("toggle_write_cycles", 256'(wcyc), 256'(8));
        check("toggle_transfers", 256'(beats_seen - base), 256'(8));
        val_mode = 0;

        // Burst at the top of the address space.
        send_cmd(32'hFFFF_FFE0, 96, ok);
        wait_idle("twrap");

        // Reset after three beats of a sixteen-beat command.
        base = beats_seen;
        send_cmd(32'h0000_4000, 512, ok);
        n = 0;
        while (beats_seen < base + 3 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("rst_mid_reached", 256'(beats_seen - base), 256'(3));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        data_q.delete();
        @(negedge clk);
        check("rst_mid_state", {251'(0), cmd_ready_o, avm_write_o, done_o, busy_o,
              data_ready_o}, 256'(16));
        repeat (4) @(negedge clk);
        send_cmd(32'h0000_5000, 200, ok);
        wait_idle("tafter_rst");

        // Randomised commands with random valid and waitrequest.
        val_mode = 1;
        wr_rand  = 1;
        for (int t = 0; t < 25; t++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 2047);
            send_cmd(ra, rb, ok);
            wait_idle("trand");
        end
        wr_rand = 0;
        val_mode = 0;

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
